// File: rtl/boot_loader.sv
// Byte-stream bootloader: parses an A5/len/payload/checksum frame from the UART,
// writes little-endian 32-bit words to instruction memory, and gates CPU reset.
module boot_loader #(
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_clr,
    output logic        wr_en,
    output logic [31:0] wr_instr,
    output logic [9:0]  wr_addr,
    output logic        cpu_rst,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] IDLE_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic [7:0]       acc_q, acc_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [23:0]      word_q, word_d;
    logic [7:0]       len_lo_q, len_lo_d;
    logic [15:0]      words_left_q, words_left_d;
    logic             mem_clr_q, mem_clr_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      wr_instr_q, wr_instr_d;
    logic [9:0]       wr_addr_q, wr_addr_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [15:0]      word_cnt;
    logic             in_frame;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idle_q       <= '0;
            acc_q        <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            len_lo_q     <= '0;
            words_left_q <= '0;
            mem_clr_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_instr_q   <= '0;
            wr_addr_q    <= '0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            idle_q       <= idle_d;
            acc_q        <= acc_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            len_lo_q     <= len_lo_d;
            words_left_q <= words_left_d;
            mem_clr_q    <= mem_clr_d;
            wr_en_q      <= wr_en_d;
            wr_instr_q   <= wr_instr_d;
            wr_addr_q    <= wr_addr_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        len_lo_d     = len_lo_q;
        words_left_d = words_left_q;
        mem_clr_d    = 1'b0;
        wr_en_d      = 1'b0;
        wr_instr_d   = wr_instr_q;
        wr_addr_d    = wr_addr_q;
        cpu_rst_d    = cpu_rst_q;
        done_d       = done_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        word_cnt     = {rx_data, len_lo_q};
        in_frame     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CSUM);

        // Address advances the cycle after the write strobe is shown
        if (wr_en_q) begin
            wr_addr_d = wr_addr_q + 10'd1;
        end

        if (!in_frame || rx_valid) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (rx_valid && rx_data == MAGIC) begin
                    state_d    = S_LEN_LO;
                    mem_clr_d  = 1'b1;
                    cpu_rst_d  = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = 2'b00;
                    acc_d      = '0;
                    wr_addr_d  = '0;
                    byte_idx_d = '0;
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    words_left_d = word_cnt;
                    if (32'(word_cnt) > DEPTH) begin
                        state_d    = S_ERROR;
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                        cpu_rst_d  = 1'b1;
                        done_d     = 1'b0;
                    end else if (word_cnt == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    acc_d      = acc_q + rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0:    word_d[7:0]   = rx_data;
                        2'd1:    word_d[15:8]  = rx_data;
                        2'd2:    word_d[23:16] = rx_data;
                        default: begin
                            wr_en_d      = 1'b1;
                            wr_instr_d   = {rx_data, word_q};
                            words_left_d = words_left_q - 16'd1;
                            if (words_left_q == 16'd1) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == acc_q) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d    = S_ERROR;
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                        cpu_rst_d  = 1'b1;
                        done_d     = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A byte arriving on the terminal count wins over the timeout
        if (in_frame && !rx_valid && idle_q == IDLE_TERM) begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            err_code_d = 2'b11;
            cpu_rst_d  = 1'b1;
            done_d     = 1'b0;
        end
    end

    assign mem_clr  = mem_clr_q;
    assign wr_en    = wr_en_q;
    assign wr_instr = wr_instr_q;
    assign wr_addr  = wr_addr_q;
    assign cpu_rst  = cpu_rst_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: normal load, bad checksum, length error,
// timeout, zero-length reload and mid-frame reset.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        mem_clr;
    logic        wr_en;
    logic [31:0] wr_instr;
    logic [9:0]  wr_addr;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int passed = 0;
    int total  = 0;
    int wr_cnt = 0;
    int wr_base;

    boot_loader #(.DEPTH(1024), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_clr(mem_clr), .wr_en(wr_en), .wr_instr(wr_instr), .wr_addr(wr_addr),
        .cpu_rst(cpu_rst), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en === 1'b1) wr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A5 02 00 | 13 00 00 00 | 93 00 50 00 | csum
    task automatic normal_frame(input logic [7:0] csum);
        send(8'hA5);
        check("start_mem_clr", 32'(mem_clr), 32'd1);
        check("start_cpu_rst", 32'(cpu_rst), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_err", 32'(err), 32'd0);
        send(8'h02);
        check("mem_clr_one_cycle", 32'(mem_clr), 32'd0);
        send(8'h00);
        send(8'h13); send(8'h00); send(8'h00);
        check("no_early_wr", 32'(wr_en), 32'd0);
        send(8'h00);
        check("w0_wr_en", 32'(wr_en), 32'd1);
        check("w0_instr", wr_instr, 32'h0000_0013);
        check("w0_addr", 32'(wr_addr), 32'd0);
        send(8'h93);
        check("w0_wr_en_drop", 32'(wr_en), 32'd0);
        check("addr_incr", 32'(wr_addr), 32'd1);
        send(8'h00); send(8'h50); send(8'h00);
        check("w1_wr_en", 32'(wr_en), 32'd1);
        check("w1_instr", wr_instr, 32'h0050_0093);
        check("w1_addr", 32'(wr_addr), 32'd1);
        send(csum);
    endtask

    initial begin
        idle(2);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_mem_clr", 32'(mem_clr), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_wr_instr", wr_instr, 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        rst = 1'b0;
        idle(2);

        // Normal load
        wr_base = wr_cnt;
        normal_frame(8'hF6);
        check("ok_done", 32'(done), 32'd1);
        check("ok_cpu_rst", 32'(cpu_rst), 32'd0);
        check("ok_err", 32'(err), 32'd0);
        idle(2);
        check("ok_wr_count", 32'(wr_cnt - wr_base), 32'd2);
        check("ok_done_hold", 32'(done), 32'd1);

        // Bad checksum
        wr_base = wr_cnt;
        normal_frame(8'hF5);
        check("csum_err", 32'(err), 32'd1);
        check("csum_code", 32'(err_code), 32'd2);
        check("csum_cpu_rst", 32'(cpu_rst), 32'd1);
        check("csum_done", 32'(done), 32'd0);
        idle(2);
        check("csum_wr_count", 32'(wr_cnt - wr_base), 32'd2);

        // Length error: N = 1025
        wr_base = wr_cnt;
        send(8'hA5);
        check("len_clear_err", 32'(err), 32'd0);
        send(8'h01);
        send(8'h04);
        check("len_err", 32'(err), 32'd1);
        check("len_code", 32'(err_code), 32'd1);
        check("len_cpu_rst", 32'(cpu_rst), 32'd1);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        idle(2);
        check("len_no_wr", 32'(wr_cnt - wr_base), 32'd0);
        check("len_sticky", 32'(err_code), 32'd1);

        // Timeout after last strobe
        wr_base = wr_cnt;
        send(8'hA5); send(8'h01); send(8'h00); send(8'h13);
        idle(15);
        check("to_not_yet", 32'(err_code), 32'd0);
        check("to_not_yet_err", 32'(err), 32'd0);
        idle(1);
        check("to_code", 32'(err_code), 32'd3);
        check("to_err", 32'(err), 32'd1);
        check("to_cpu_rst", 32'(cpu_rst), 32'd1);
        idle(2);
        check("to_no_wr", 32'(wr_cnt - wr_base), 32'd0);

        // Zero-length frame; first byte lands on the terminal idle count
        wr_base = wr_cnt;
        send(8'hA5);
        idle(15);
        send(8'h00);
        check("term_no_timeout", 32'(err), 32'd0);
        send(8'h00);
        send(8'h00);
        check("zero_done", 32'(done), 32'd1);
        check("zero_cpu_rst", 32'(cpu_rst), 32'd0);
        check("zero_err", 32'(err), 32'd0);
        idle(2);
        check("zero_no_wr", 32'(wr_cnt - wr_base), 32'd0);

        // Reload after zero-length image
        wr_base = wr_cnt;
        normal_frame(8'hF6);
        check("reload_done", 32'(done), 32'd1);
        check("reload_cpu_rst", 32'(cpu_rst), 32'd0);
        idle(2);
        check("reload_wr_count", 32'(wr_cnt - wr_base), 32'd2);

        // Reset mid-word
        send(8'hA5); send(8'h02); send(8'h00); send(8'h13); send(8'h00);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("mid_rst_wr_instr", wr_instr, 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        wr_base = wr_cnt;
        normal_frame(8'hF6);
        check("post_rst_done", 32'(done), 32'd1);
        idle(2);
        check("post_rst_wr_count", 32'(wr_cnt - wr_base), 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-stream bootloader between the UART receiver and the instruction memory write port. It parses a framed program image, assembles little-endian 32-bit instructions, and issues one write pulse per word to instruction memory. It holds the CPU in reset until a complete frame with a valid checksum has been loaded. It also reports length, checksum and timeout errors.

## Interface
- DEPTH, 1024: instruction memory depth in words; the maximum accepted word count.
- TIMEOUT_CYCLES, 1_000_000: maximum idle cycles between bytes inside a frame.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  received byte; valid only when rx_valid=1.
- rx_valid  input  1  single-cycle strobe, one per received byte.
- mem_clr  output  1  one-cycle pulse on frame start; the top level ORs it into the instruction memory reset to clear its write pointer.
- wr_en  output  1  one-cycle instruction memory write strobe.
- wr_instr  output  32  assembled instruction; valid while wr_en=1.
- wr_addr  output  10  word index of the current write; for debug and verification only, because the memory auto-increments.
- cpu_rst  output  1  CPU/PC reset request; active-high.
- done  output  1  image loaded and checksum matched.
- err  output  1  frame aborted.
- err_code  output  2  error cause: 01 length, 10 checksum, 11 timeout, 00 none.

## Operation
- Frame format:
  - 0xA5 magic byte.
  - count_lo, then count_hi: word count N, 16-bit.
  - 4·N payload bytes, least significant byte first per word.
  - 1 checksum byte: sum of payload bytes mod 256.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
- IDLE, DONE, ERROR:
  - rx_valid with 0xA5 → LEN_LO.
  - On that transition: mem_clr pulses, cpu_rst=1, done=0, err=0, err_code=00, checksum accumulator=0, wr_addr=0, byte index=0.
  - Any other byte is ignored.
- LEN_LO: latch count_lo → LEN_HI.
- LEN_HI: latch count_hi, then:
  - N > DEPTH → ERROR with code 01.
  - N = 0 → CSUM.
  - Otherwise → DATA.
- DATA:
  - Each byte is shifted into bits [8·k+7:8·k] for byte index k = 0..3, and added to the 8-bit accumulator (wraps mod 256).
  - On k=3 the cycle after acceptance shows wr_en=1 with the full word and the current wr_addr. wr_addr then increments and k returns to 0.
  - After word N-1 is written → CSUM.
- CSUM:
  - Received byte equals accumulator → DONE: done=1, cpu_rst=0.
  - Otherwise → ERROR with code 10.
- Timeout:
  - An idle counter runs in LEN_LO, LEN_HI, DATA and CSUM, and clears on every rx_valid.
  - The counter reaching TIMEOUT_CYCLES-1 → ERROR with code 11.
  - If rx_valid arrives in the same cycle as the terminal count, the byte is accepted and no timeout occurs.
- ERROR: err=1, cpu_rst=1, done=0. Error state is sticky until the next 0xA5.
- Any 0xA5 received inside a frame (LEN_LO to CSUM) is treated as data, never as a restart.

## Timing
- Reset values:
  - cpu_rst=1.
  - mem_clr, wr_en, done, err: all 0.
  - err_code=00, wr_instr=0, wr_addr=0.
  - State IDLE; counters and accumulator 0.
- Reset mid-frame aborts immediately and returns to IDLE. Memory contents are not touched; the next frame clears the memory pointer via mem_clr.
- mem_clr is asserted in the cycle after the 0xA5 strobe, for exactly 1 cycle.
- wr_en is asserted in the cycle after the 4th byte strobe of a word, for exactly 1 cycle. Never more than one write per 4 bytes.
- done, cpu_rst and err update in the cycle after the checksum strobe, or after the error condition.
- rx_valid may be asserted on back-to-back cycles. Every byte is accepted with zero stall; there is no backpressure.
- wr_addr is 10 bits. With N=DEPTH=1024 the last write has address 1023; the post-increment wrap to 0 is harmless.

## Test plan
- Normal load:
  - Stimulus: A5 02 00 | 13 00 00 00 | 93 00 50 00 | F6.
  - Required response: mem_clr pulse; wr_en with 0x00000013 at addr 0, then wr_en with 0x00500093 at addr 1; then done=1, cpu_rst=0.
- Bad checksum:
  - Stimulus: the same frame with checksum F5.
  - Required response: both writes occur; then err=1, err_code=10, cpu_rst=1, done=0.
- Length error:
  - Stimulus: A5 01 04 (N=1025, DEPTH=1024).
  - Required response: ERROR with code 01 after count_hi; no wr_en.
  - Follow-up: the next bytes 13 00 00 00 are ignored.
- Timeout (TIMEOUT_CYCLES=16):
  - Stimulus: A5 01 00 13, then silence.
  - Required response: err_code=11 exactly 16 cycles after the last strobe; no wr_en.
- Zero-length frame and reload:
  - Stimulus: A5 00 00 00.
  - Required response: done=1 with no writes.
  - Follow-up: the normal-load frame then re-asserts cpu_rst, pulses mem_clr, and completes with done=1.
- Reset mid-word:
  - Stimulus: assert rst after byte 2 of word 0.
  - Required response: all outputs return to their reset values asynchronously.
  - Follow-up: a fresh normal-load frame writes the first word correctly at addr 0.
